// File: rtl/sap_pkg.sv
// Shared SAP datapath definitions: default width, control-word bit positions
// and flag bit positions used by the ALU operand stage.
package sap_pkg;

  localparam int DATA_WIDTH = 8;

  localparam int CW_AI    = 0;
  localparam int CW_AO    = 1;
  localparam int CW_BI    = 2;
  localparam int CW_SU    = 3;
  localparam int CW_EO    = 4;
  localparam int CW_FI    = 5;
  localparam int CW_WIDTH = 6;

  localparam int FLAG_C     = 0;
  localparam int FLAG_Z     = 1;
  localparam int FLAG_WIDTH = 2;

endpackage

// File: rtl/sap_load_register.sv
// Load-enabled register with asynchronous active-low reset to a fixed value.
module sap_load_register #(
  parameter int               WIDTH     = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      q <= RESET_VAL;
    else if (load)
      q <= d;
  end

endmodule

// File: rtl/sap_alu_operand_stage.sv
// Operand/flag stage feeding the SAP carry-lookahead adder slices: holds A and B,
// applies subtract inversion, captures carry/zero flags and muxes A or the sum onto the bus.
module sap_alu_operand_stage
  import sap_pkg::*;
#(
  parameter int                    DATA_WIDTH = sap_pkg::DATA_WIDTH,
  parameter logic [DATA_WIDTH-1:0] RESET_VAL  = '0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] bus_in,
  input  logic                  ai,
  input  logic                  ao,
  input  logic                  bi,
  input  logic                  su,
  input  logic                  eo,
  input  logic                  fi,
  input  logic [DATA_WIDTH-1:0] alu_sum,
  input  logic                  alu_cout,
  output logic [DATA_WIDTH-1:0] adder_a,
  output logic [DATA_WIDTH-1:0] adder_b,
  output logic                  adder_cin,
  output logic [DATA_WIDTH-1:0] bus_out,
  output logic                  bus_oe,
  output logic                  flag_c,
  output logic                  flag_z,
  output logic                  err_bus
);

  logic [CW_WIDTH-1:0]   ctrl;
  logic [DATA_WIDTH-1:0] a_q;
  logic [DATA_WIDTH-1:0] b_q;
  logic [FLAG_WIDTH-1:0] flags_q;

  assign ctrl = {fi, eo, su, bi, ao, ai};

  sap_load_register #(.WIDTH(DATA_WIDTH), .RESET_VAL(RESET_VAL)) u_reg_a (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (ctrl[CW_AI]),
    .d     (bus_in),
    .q     (a_q)
  );

  sap_load_register #(.WIDTH(DATA_WIDTH), .RESET_VAL(RESET_VAL)) u_reg_b (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (ctrl[CW_BI]),
    .d     (bus_in),
    .q     (b_q)
  );

  // Subtraction is A + ~B + 1: invert B and feed su as the slice carry-in.
  assign adder_a   = a_q;
  assign adder_b   = b_q ^ {DATA_WIDTH{ctrl[CW_SU]}};
  assign adder_cin = ctrl[CW_SU];

  // The sum wins when both drivers are enabled; err_bus records that contention.
  always_comb begin
    bus_out = '0;
    if (ctrl[CW_EO])
      bus_out = alu_sum;
    else if (ctrl[CW_AO])
      bus_out = a_q;
  end

  assign bus_oe = ctrl[CW_AO] | ctrl[CW_EO];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flags_q <= '0;
      err_bus <= 1'b0;
    end else begin
      if (ctrl[CW_FI]) begin
        flags_q[FLAG_C] <= alu_cout;
        flags_q[FLAG_Z] <= (alu_sum == '0);
      end
      if (ctrl[CW_AO] && ctrl[CW_EO])
        err_bus <= 1'b1;
    end
  end

  assign flag_c = flags_q[FLAG_C];
  assign flag_z = flags_q[FLAG_Z];

endmodule

// File: tb/tb_sap_alu_operand_stage.sv
// Directed self-checking bench for sap_alu_operand_stage, with a behavioural adder closing the loop.
module tb_sap_alu_operand_stage;

  logic       clk;
  logic       rst_n;
  logic [7:0] bus_in;
  logic       ai, ao, bi, su, eo, fi;
  logic [7:0] alu_sum;
  logic       alu_cout;
  logic [7:0] adder_a, adder_b;
  logic       adder_cin;
  logic [7:0] bus_out;
  logic       bus_oe;
  logic       flag_c, flag_z, err_bus;

  int checks = 0;
  int errors = 0;

  sap_alu_operand_stage #(.DATA_WIDTH(8), .RESET_VAL(8'h00)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus_in    (bus_in),
    .ai        (ai),
    .ao        (ao),
    .bi        (bi),
    .su        (su),
    .eo        (eo),
    .fi        (fi),
    .alu_sum   (alu_sum),
    .alu_cout  (alu_cout),
    .adder_a   (adder_a),
    .adder_b   (adder_b),
    .adder_cin (adder_cin),
    .bus_out   (bus_out),
    .bus_oe    (bus_oe),
    .flag_c    (flag_c),
    .flag_z    (flag_z),
    .err_bus   (err_bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Stand-in for the cascaded adder slices.
  logic [8:0] full_sum;
  always_comb begin
    full_sum = {1'b0, adder_a} + {1'b0, adder_b} + {8'h00, adder_cin};
    alu_sum  = full_sum[7:0];
    alu_cout = full_sum[8];
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    ai = 0; ao = 0; bi = 0; eo = 0; fi = 0;
  endtask

  task automatic applyStimulus(input logic [7:0] a_val, input logic [7:0] b_val);
    idle();
    bus_in = a_val; ai = 1;
    tick();
    ai = 0; bus_in = b_val; bi = 1;
    tick();
    bi = 0;
    #1;
  endtask

  task automatic test_reset();
    checks++;
    if (adder_a !== 8'h00 || flag_c !== 1'b0 || flag_z !== 1'b0 || err_bus !== 1'b0 || bus_oe !== 1'b0) begin
      errors++;
      $display("[TB] FAIL power_on_reset: a=%h c=%b z=%b err=%b oe=%b expected 00 0 0 0 0", adder_a, flag_c, flag_z, err_bus, bus_oe);
    end
    idle(); su = 0;
    bus_in = 8'h5A; ai = 1; bi = 1; fi = 1;
    tick();
    idle();
    #1;
    checks++;
    if (adder_a !== 8'h5A) begin
      errors++;
      $display("[TB] FAIL preload_a: got %h expected 5a", adder_a);
    end
    #1 rst_n = 0;
    #1;
    checks++;
    if (adder_a !== 8'h00 || adder_b !== 8'h00 || flag_c !== 1'b0 || flag_z !== 1'b0 || err_bus !== 1'b0 || bus_oe !== 1'b0) begin
      errors++;
      $display("[TB] FAIL async_reset: a=%h b=%h c=%b z=%b err=%b oe=%b expected all zero", adder_a, adder_b, flag_c, flag_z, err_bus, bus_oe);
    end
    @(negedge clk);
    rst_n = 1;
    #1;
  endtask

  task automatic test_add();
    applyStimulus(8'h2C, 8'h13);
    su = 0; eo = 1; fi = 1;
    #1;
    checks++;
    if (bus_out !== 8'h3F || bus_oe !== 1'b1) begin
      errors++;
      $display("[TB] FAIL add_bus: got %h oe=%b expected 3f oe=1", bus_out, bus_oe);
    end
    tick();
    idle();
    #1;
    checks++;
    if (flag_c !== 1'b0 || flag_z !== 1'b0) begin
      errors++;
      $display("[TB] FAIL add_flags: got c=%b z=%b expected c=0 z=0", flag_c, flag_z);
    end
  endtask

  task automatic test_overflow();
    applyStimulus(8'hFF, 8'h01);
    su = 0; fi = 1;
    tick();
    idle();
    #1;
    checks++;
    if (flag_c !== 1'b1 || flag_z !== 1'b1) begin
      errors++;
      $display("[TB] FAIL overflow_flags: got c=%b z=%b expected c=1 z=1", flag_c, flag_z);
    end
    bus_in = 8'hAA;
    tick();
    checks++;
    if (adder_a !== 8'hFF || adder_b !== 8'h01 || flag_c !== 1'b1 || flag_z !== 1'b1) begin
      errors++;
      $display("[TB] FAIL hold: got a=%h b=%h c=%b z=%b expected ff 01 1 1", adder_a, adder_b, flag_c, flag_z);
    end
  endtask

  task automatic test_subtract();
    applyStimulus(8'h10, 8'h11);
    su = 1;
    #1;
    checks++;
    if (adder_b !== 8'hEE || adder_cin !== 1'b1) begin
      errors++;
      $display("[TB] FAIL sub_operands: got b=%h cin=%b expected ee 1", adder_b, adder_cin);
    end
    eo = 1; fi = 1;
    #1;
    checks++;
    if (bus_out !== 8'hFF) begin
      errors++;
      $display("[TB] FAIL sub_bus: got %h expected ff", bus_out);
    end
    tick();
    idle();
    su = 0;
    #1;
    checks++;
    if (flag_c !== 1'b0 || flag_z !== 1'b0 || adder_b !== 8'h11 || adder_cin !== 1'b0) begin
      errors++;
      $display("[TB] FAIL sub_flags: got c=%b z=%b b=%h cin=%b expected 0 0 11 0", flag_c, flag_z, adder_b, adder_cin);
    end
  endtask

  task automatic test_same_edge();
    applyStimulus(8'h01, 8'hFF);
    su = 0; bus_in = 8'h05; ai = 1; fi = 1; ao = 1;
    #1;
    checks++;
    if (bus_out !== 8'h01) begin
      errors++;
      $display("[TB] FAIL load_drive_bus: got %h expected 01", bus_out);
    end
    tick();
    idle();
    #1;
    checks++;
    if (flag_c !== 1'b1 || flag_z !== 1'b1 || adder_a !== 8'h05) begin
      errors++;
      $display("[TB] FAIL same_edge: got c=%b z=%b a=%h expected 1 1 05", flag_c, flag_z, adder_a);
    end
  endtask

  task automatic test_both_load();
    idle(); su = 0;
    bus_in = 8'h33; ai = 1; bi = 1;
    tick();
    idle();
    #1;
    checks++;
    if (adder_a !== 8'h33 || adder_b !== 8'h33) begin
      errors++;
      $display("[TB] FAIL both_load: got a=%h b=%h expected 33 33", adder_a, adder_b);
    end
  endtask

  task automatic test_contention();
    ao = 1; eo = 1;
    #1;
    checks++;
    if (bus_out !== 8'h66 || err_bus !== 1'b0) begin
      errors++;
      $display("[TB] FAIL contention_pre: got bus=%h err=%b expected 66 0", bus_out, err_bus);
    end
    tick();
    idle();
    #1;
    checks++;
    if (err_bus !== 1'b1 || bus_oe !== 1'b0 || bus_out !== 8'h00) begin
      errors++;
      $display("[TB] FAIL contention_set: got err=%b oe=%b bus=%h expected 1 0 00", err_bus, bus_oe, bus_out);
    end
    ao = 1;
    tick();
    tick();
    ao = 0;
    #1;
    checks++;
    if (err_bus !== 1'b1) begin
      errors++;
      $display("[TB] FAIL err_sticky: got %b expected 1", err_bus);
    end
    #1 rst_n = 0;
    #1;
    checks++;
    if (err_bus !== 1'b0) begin
      errors++;
      $display("[TB] FAIL err_clear: got %b expected 0", err_bus);
    end
    @(negedge clk);
    rst_n = 1;
    tick();
    checks++;
    if (err_bus !== 1'b0 || adder_a !== 8'h00) begin
      errors++;
      $display("[TB] FAIL post_reset: got err=%b a=%h expected 0 00", err_bus, adder_a);
    end
  endtask

  initial begin
    rst_n = 0; bus_in = 8'h00; su = 0;
    idle();
    #12 rst_n = 1;
    #1;
    test_reset();
    test_add();
    test_overflow();
    test_subtract();
    test_same_edge();
    test_both_load();
    test_contention();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
